// File: rtl/rsa_keygen_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_keygen_ctrl
//
// Sequencer around an external private-exponent generator. The generator
// takes (e, totient) and eventually returns d with a completion flag.
// This block:
//   - accepts p, q and e on a start pulse;
//   - computes the modulus n = p*q and the totient (p-1)*(q-1);
//   - validates the operands;
//   - clears and launches the generator;
//   - waits for the generator, giving up after a timeout;
//   - holds the resulting key pair (n, d) until the next accepted start.
//
// Optional build macro: COPRIME_CHECK_EN
//   When defined, an iterative Euclid stage rejects an e that shares a
//   factor with the totient before the generator is launched.
//   When undefined, that stage is absent. A non-coprime e then runs into
//   the generator timeout.
//
// Parameters
//   INPUTSIZE  width of p, q, e, totient and d
//   TIMEOUT    maximum WAIT cycles for gen_flag after launch
//   TMO_W      timeout counter width, 2**TMO_W > TIMEOUT
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle request, only honoured in IDLE
//   p, q, e      operands, sampled together with start
//   busy         high from the cycle after an accepted start until DONE/ERR
//   gen_clr      one-cycle generator clear, asserted in LAUNCH
//   gen_e        e presented to the generator, stable during WAIT
//   gen_totient  totient presented to the generator, stable during WAIT
//   gen_d        d returned by the generator
//   gen_flag     generator finished
//   n_out        modulus p*q
//   d_out        private exponent
//   key_valid    n_out/d_out valid, held until the next accepted start
//   key_err      operation failed, held until the next accepted start
//   err_code     00 bad input, 01 totient out of range,
//                10 not coprime, 11 timeout
// ---------------------------------------------------------------------------
module rsa_keygen_ctrl #(
    parameter int INPUTSIZE = 12,
    parameter int TIMEOUT   = 16384,
    parameter int TMO_W     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INPUTSIZE-1:0]   p,
    input  logic [INPUTSIZE-1:0]   q,
    input  logic [INPUTSIZE-1:0]   e,
    output logic                   busy,
    output logic                   gen_clr,
    output logic [INPUTSIZE-1:0]   gen_e,
    output logic [INPUTSIZE-1:0]   gen_totient,
    input  logic [INPUTSIZE-1:0]   gen_d,
    input  logic                   gen_flag,
    output logic [2*INPUTSIZE-1:0] n_out,
    output logic [INPUTSIZE-1:0]   d_out,
    output logic                   key_valid,
    output logic                   key_err,
    output logic [1:0]             err_code
);

    localparam int W  = INPUTSIZE;
    localparam int W2 = 2 * INPUTSIZE;

    localparam logic [W-1:0]     ONE_W    = W'(1);
    localparam logic [W-1:0]     TWO_W    = W'(2);
    localparam logic [W2-1:0]    ONE_W2   = W2'(1);
    // Last WAIT cycle index. Counting WAIT cycles 0..TIMEOUT-1 gives
    // exactly TIMEOUT chances to see gen_flag.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

`ifdef COPRIME_CHECK_EN
    localparam int GCD_MAX  = 2 * INPUTSIZE;
    localparam int GCD_IT_W = $clog2(GCD_MAX + 1);
    localparam logic [GCD_IT_W-1:0] GCD_LAST = GCD_IT_W'(GCD_MAX);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_CHECK,
`ifdef COPRIME_CHECK_EN
        S_GCD,
`endif
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_INPUT   = 2'b00,
        ERR_RANGE   = 2'b01,
        ERR_COPRIME = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    state_e            state_q, state_d;
    logic [W-1:0]      p_q, p_d;
    logic [W-1:0]      q_q, q_d;
    logic [W-1:0]      e_q, e_d;
    logic [W2-1:0]     n_q, n_d;
    logic [W2-1:0]     tot_q, tot_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      gen_e_q, gen_e_d;
    logic [W-1:0]      gen_tot_q, gen_tot_d;
    logic [W2-1:0]     n_out_q, n_out_d;
    logic [W-1:0]      d_out_q, d_out_d;
    logic              key_valid_q, key_valid_d;
    logic              key_err_q, key_err_d;
    logic [1:0]        err_code_q, err_code_d;

`ifdef COPRIME_CHECK_EN
    logic [W-1:0]          gcd_a_q, gcd_a_d;
    logic [W-1:0]          gcd_b_q, gcd_b_d;
    logic [GCD_IT_W-1:0]   gcd_it_q, gcd_it_d;
`endif

    // Operands widened before the multiply. This keeps the product at the
    // full 2*W bits. (p-1) is formed at the wide width. p<2 is rejected in
    // CHECK anyway, so a p of 0 cannot matter.
    logic [W2-1:0] p_ext, q_ext, prod_n, prod_tot;

    assign p_ext    = {{W{1'b0}}, p_q};
    assign q_ext    = {{W{1'b0}}, q_q};
    assign prod_n   = p_ext * q_ext;
    assign prod_tot = (p_ext - ONE_W2) * (q_ext - ONE_W2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            q_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            tot_q       <= '0;
            cnt_q       <= '0;
            gen_e_q     <= '0;
            gen_tot_q   <= '0;
            n_out_q     <= '0;
            d_out_q     <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            err_code_q  <= '0;
`ifdef COPRIME_CHECK_EN
            gcd_a_q     <= '0;
            gcd_b_q     <= '0;
            gcd_it_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            e_q         <= e_d;
            n_q         <= n_d;
            tot_q       <= tot_d;
            cnt_q       <= cnt_d;
            gen_e_q     <= gen_e_d;
            gen_tot_q   <= gen_tot_d;
            n_out_q     <= n_out_d;
            d_out_q     <= d_out_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            err_code_q  <= err_code_d;
`ifdef COPRIME_CHECK_EN
            gcd_a_q     <= gcd_a_d;
            gcd_b_q     <= gcd_b_d;
            gcd_it_q    <= gcd_it_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        e_d         = e_q;
        n_d         = n_q;
        tot_d       = tot_q;
        cnt_d       = cnt_q;
        gen_e_d     = gen_e_q;
        gen_tot_d   = gen_tot_q;
        n_out_d     = n_out_q;
        d_out_d     = d_out_q;
        key_valid_d = key_valid_q;
        key_err_d   = key_err_q;
        err_code_d  = err_code_q;
`ifdef COPRIME_CHECK_EN
        gcd_a_d     = gcd_a_q;
        gcd_b_d     = gcd_b_q;
        gcd_it_d    = gcd_it_q;
`endif

        // key_valid/key_err are set on the edge that enters DONE/ERR.
        // They are therefore already visible during that one-cycle state.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d         = p;
                    q_d         = q;
                    e_d         = e;
                    key_valid_d = 1'b0;
                    key_err_d   = 1'b0;
                    err_code_d  = '0;
                    n_out_d     = '0;
                    d_out_d     = '0;
                    state_d     = S_CALC;
                end
            end

            S_CALC: begin
                n_d     = prod_n;
                tot_d   = prod_tot;
                state_d = S_CHECK;
            end

            S_CHECK: begin
                if ((p_q < TWO_W) || (q_q < TWO_W) || (e_q < TWO_W)) begin
                    key_err_d  = 1'b1;
                    err_code_d = ERR_INPUT;
                    state_d    = S_ERR;
                end else if (|tot_q[W2-1:W]) begin
                    key_err_d  = 1'b1;
                    err_code_d = ERR_RANGE;
                    state_d    = S_ERR;
                end else if ({{W{1'b0}}, e_q} >= tot_q) begin
                    key_err_d  = 1'b1;
                    err_code_d = ERR_INPUT;
                    state_d    = S_ERR;
                end else begin
`ifdef COPRIME_CHECK_EN
                    gcd_a_d  = tot_q[W-1:0];
                    gcd_b_d  = e_q;
                    gcd_it_d = '0;
                    state_d  = S_GCD;
`else
                    state_d  = S_LAUNCH;
`endif
                end
            end

`ifdef COPRIME_CHECK_EN
            // One Euclid remainder step per cycle. Once b reaches zero,
            // a holds gcd(totient, e). The iteration guard cannot trip for
            // W-bit operands. It only bounds the state against corruption.
            S_GCD: begin
                if (gcd_b_q == '0) begin
                    if (gcd_a_q == ONE_W) begin
                        state_d = S_LAUNCH;
                    end else begin
                        key_err_d  = 1'b1;
                        err_code_d = ERR_COPRIME;
                        state_d    = S_ERR;
                    end
                end else if (gcd_it_q == GCD_LAST) begin
                    key_err_d  = 1'b1;
                    err_code_d = ERR_COPRIME;
                    state_d    = S_ERR;
                end else begin
                    gcd_a_d  = gcd_b_q;
                    gcd_b_d  = gcd_a_q % gcd_b_q;
                    gcd_it_d = gcd_it_q + 1'b1;
                end
            end
`endif

            S_LAUNCH: begin
                gen_e_d   = e_q;
                gen_tot_d = tot_q[W-1:0];
                cnt_d     = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                if (gen_flag) begin
                    d_out_d     = gen_d;
                    n_out_d     = n_q;
                    key_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    key_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign gen_clr     = (state_q == S_LAUNCH);
    assign gen_e       = gen_e_q;
    assign gen_totient = gen_tot_q;
    assign n_out       = n_out_q;
    assign d_out       = d_out_q;
    assign key_valid   = key_valid_q;
    assign key_err     = key_err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for rsa_keygen_ctrl. It drives directed and random operands.
// A behavioural generator answers gen_clr with a modular inverse after a
// chosen delay. Results are compared against a plain-arithmetic model
// of the key sequencing rules.
// ---------------------------------------------------------------------------
module tb_rsa_keygen_ctrl;

    localparam int W     = 12;
    localparam int TMO   = 40;
    localparam int LIMIT = TMO + 40;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    p, q, e;
    logic            busy, gen_clr;
    logic [W-1:0]    gen_e, gen_totient;
    logic [W-1:0]    gen_d = '0;
    logic            gen_flag = 1'b0;
    logic [2*W-1:0]  n_out;
    logic [W-1:0]    d_out;
    logic            key_valid, key_err;
    logic [1:0]      err_code;

    int n_total = 0;
    int n_bad   = 0;

    int unsigned gen_delay = 0;
    int unsigned clr_cnt   = 0;
    int unsigned kv_rise   = 0;
    int unsigned gcnt      = 0;
    bit          armed     = 1'b0;
    bit          kv_prev   = 1'b0;

    rsa_keygen_ctrl #(
        .INPUTSIZE (W),
        .TIMEOUT   (TMO),
        .TMO_W     (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .p           (p),
        .q           (q),
        .e           (e),
        .busy        (busy),
        .gen_clr     (gen_clr),
        .gen_e       (gen_e),
        .gen_totient (gen_totient),
        .gen_d       (gen_d),
        .gen_flag    (gen_flag),
        .n_out       (n_out),
        .d_out       (d_out),
        .key_valid   (key_valid),
        .key_err     (key_err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Smallest x with a*x = 1 (mod m), or 0 when no inverse exists.
    function automatic int unsigned inv_mod(input int unsigned a, input int unsigned m);
        for (int unsigned x = 1; x < m; x++)
            if (((a * x) % m) == 1) return x;
        return 0;
    endfunction

    // Reference outcome of one operation.
    // early: rejected before the generator or coprime stage.
    function automatic void ref_model(input int unsigned pp, qq, ee,
                                      output bit v, output bit early,
                                      output int unsigned code, n, d, tot);
        v = 0; early = 1; code = 0; n = 0; d = 0; tot = 0;
        if (pp < 2 || qq < 2 || ee < 2) return;
        tot = (pp - 1) * (qq - 1);
        if (tot >= (1 << W)) begin code = 1; return; end
        if (ee >= tot) return;
        early = 0;
        d = inv_mod(ee, tot);
        if (d == 0) begin
`ifdef COPRIME_CHECK_EN
            code = 2;
`else
            code = 3;
`endif
            return;
        end
        v = 1;
        n = pp * qq;
    endfunction

    // Behavioural generator. It reacts one time unit after each rising edge.
    // Delay 0 raises the flag in the first WAIT cycle.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            armed    = 1'b0;
            gen_flag = 1'b0;
        end else begin
            if (gen_flag) gen_flag = 1'b0;
            if (gen_clr) begin
                clr_cnt++;
                armed = 1'b1;
                gcnt  = gen_delay;
            end else if (armed) begin
                if (gcnt == 0) begin
                    int unsigned inv;
                    armed = 1'b0;
                    inv = inv_mod(gen_e, gen_totient);
                    if (inv != 0) begin
                        gen_d    = W'(inv);
                        gen_flag = 1'b1;
                    end
                end else begin
                    gcnt--;
                end
            end
        end
        if (key_valid && !kv_prev) kv_rise++;
        kv_prev = key_valid;
    end

    task automatic run_op(input int unsigned pp, qq, ee, dly);
        bit v, early, launched;
        int unsigned code, n, d, tot, base;
        int exp_lat, cyc;
        ref_model(pp, qq, ee, v, early, code, n, d, tot);
`ifdef COPRIME_CHECK_EN
        launched = v;
        exp_lat  = early ? 3 : -1;
`else
        launched = !early;
        exp_lat  = early ? 3 : (v ? 5 + int'(dly) : 4 + TMO);
`endif
        base      = clr_cnt;
        gen_delay = dly;
        @(negedge clk);
        p = W'(pp); q = W'(qq); e = W'(ee); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check_eq("busy_run", busy, 1);
        while (!(key_valid || key_err) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("finished", key_valid | key_err, 1);
        if (exp_lat >= 0) check_eq("latency", cyc, exp_lat);
        check_eq("key_valid", key_valid, v);
        check_eq("key_err", key_err, !v);
        check_eq("excl", key_valid & key_err, 0);
        check_eq("err_code", err_code, code);
        check_eq("n_out", n_out, n);
        check_eq("d_out", d_out, d);
        check_eq("busy_end", busy, 0);
        check_eq("clr_cnt", clr_cnt - base, launched);
        if (launched) begin
            check_eq("gen_e", gen_e, ee);
            check_eq("gen_tot", gen_totient, tot);
        end
        @(negedge clk);
        check_eq("held", {key_valid, key_err}, {v, !v});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned base_c, base_k, pp, qq, ee;
        rst = 1'b1; start = 1'b0; p = '0; q = '0; e = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {busy, gen_clr, key_valid, key_err, err_code, gen_e, gen_totient}, 0);
        check_eq("rst_key", {n_out, d_out}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", busy, 0);

        run_op(5, 11, 3, 2);     // n=55 d=27
        run_op(1, 11, 3, 1);     // bad input
        run_op(97, 97, 5, 1);    // totient 9216 out of range
        run_op(5, 11, 5, 1);     // not coprime: code 10 or timeout
        run_op(5, 11, 3, 0);     // flag in first WAIT cycle
        run_op(3, 5, 8, 0);      // e == totient
        run_op(3, 5, 7, 3);      // e == totient-1
        run_op(64, 66, 2, 1);    // totient 4095, largest in range
        run_op(65, 65, 3, 0);    // totient 4096, just out of range
        run_op(2, 2, 2, 0);      // totient 1

        // Reset while waiting on the generator aborts everything.
        gen_delay = 30;
        base_c = clr_cnt;
        @(negedge clk);
        p = 12'd5; q = 12'd11; e = 12'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && clr_cnt == base_c; i++) @(negedge clk);
        check_eq("rst_launch", clr_cnt - base_c, 1);
        repeat (3) @(negedge clk);
        check_eq("rst_wait_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_ctl", {busy, gen_clr, key_valid, key_err, err_code, gen_e, gen_totient}, 0);
        check_eq("rst_mid_key", {n_out, d_out}, 0);
        rst = 1'b0;
        @(negedge clk);
        run_op(5, 11, 3, 2);

        // start held for three cycles, then a stray start during WAIT.
        gen_delay = 8;
        base_c = clr_cnt;
        base_k = kv_rise;
        @(negedge clk);
        p = 12'd5; q = 12'd11; e = 12'd3; start = 1'b1;
        @(negedge clk);
        p = 12'd7; q = 12'd13; e = 12'd5;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && clr_cnt == base_c; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        p = 12'd9; q = 12'd7; e = 12'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < LIMIT && !(key_valid || key_err); i++) @(negedge clk);
        repeat (12) @(negedge clk);
        check_eq("hold_clr", clr_cnt - base_c, 1);
        check_eq("hold_kv_rise", kv_rise - base_k, 1);
        check_eq("hold_valid", {key_valid, key_err}, 2'b10);
        check_eq("hold_n", n_out, 55);
        check_eq("hold_d", d_out, 27);

        for (int i = 0; i < 40; i++) begin
            pp = $urandom_range(0, 70);
            qq = $urandom_range(0, 70);
            ee = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 40);
            run_op(pp, qq, ee, $urandom_range(0, 10));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
